// File: rtl/vcve2_fetch_aligner.sv
// -----------------------------------------------------------------------------
// vcve2_fetch_aligner
//
// Turns the word-aligned 32-bit fetch stream into one instruction per cycle
// for the compressed decoder. A small FIFO holds fetch words; a half-pointer
// state (ALIGNED / UNALIGNED) says whether the current instruction starts in
// the lower or upper halfword of the head word. 32-bit instructions that start
// in the upper half straddle into the next word. The PC of the presented
// instruction is tracked alongside.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   branch_i             redirect: flush FIFO, restart at branch_addr_i
//   branch_addr_i        redirect target (bit 0 ignored)
//   in_valid_i/ready_o   fetch word handshake
//   in_rdata_i, in_err_i fetch word and its bus error flag
//   out_valid_o/ready_i  aligned instruction handshake
//   out_rdata_o          instruction; RVC in [15:0] with [31:16] = 0
//   out_addr_o           PC of out_rdata_o
//   out_is_compressed_o  out_rdata_o[1:0] != 2'b11
//   out_err_o            OR of the error flags of all contributing words
// -----------------------------------------------------------------------------
module vcve2_fetch_aligner #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } entry_t;

  typedef enum logic {
    ALIGNED   = 1'b0,
    UNALIGNED = 1'b1
  } state_e;

  entry_t        fifo_q [DEPTH];
  logic [CW-1:0] count_q;
  state_e        state_q;
  logic [31:0]   addr_q;

  entry_t        head_e;
  entry_t        next_e;
  logic          has_one;
  logic          has_two;
  logic          valid_c;
  logic [31:0]   rdata_c;
  logic          err_c;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] wr_idx;

  // Entry 0 is always the head; entries shift down on pop.
  assign head_e  = fifo_q[0];
  assign next_e  = fifo_q[1];
  assign has_one = (count_q != '0);
  assign has_two = (count_q >= CW'(2));

  // ---------------------------------------------------------------------------
  // Instruction extraction from head/next according to the half pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_c = 1'b0;
    rdata_c = '0;
    err_c   = 1'b0;
    if (state_q == ALIGNED) begin
      valid_c = has_one;
      err_c   = head_e.err;
      if (head_e.rdata[1:0] != 2'b11) rdata_c = {16'h0, head_e.rdata[15:0]};
      else                            rdata_c = head_e.rdata;
    end else if (head_e.rdata[17:16] != 2'b11) begin
      valid_c = has_one;
      rdata_c = {16'h0, head_e.rdata[31:16]};
      err_c   = head_e.err;
    end else if (has_two) begin
      valid_c = 1'b1;
      rdata_c = {next_e.rdata[15:0], head_e.rdata[31:16]};
      err_c   = head_e.err | next_e.err;
    end else begin
      // Straddling instruction whose first word already faulted: there is no
      // point waiting for the second half, report the error right away.
      valid_c = has_one && head_e.err;
      rdata_c = {16'h0, head_e.rdata[31:16]};
      err_c   = head_e.err;
    end
  end

  // Payload outputs are forced to zero while nothing is presented, so stale
  // or never-written FIFO contents are not visible.
  assign out_valid_o         = valid_c;
  assign out_rdata_o         = valid_c ? rdata_c : '0;
  assign out_err_o           = valid_c & err_c;
  assign out_is_compressed_o = valid_c & (rdata_c[1:0] != 2'b11);
  assign out_addr_o          = addr_q;

  assign in_ready_o = (count_q < CW'(DEPTH));

  // A redirect cancels both a same-cycle push and a same-cycle accept.
  assign accept = out_valid_o && out_ready_i && !branch_i;
  assign push   = in_valid_i && in_ready_o && !branch_i;
  // A compressed instruction in the lower half leaves the upper half in the
  // head word, so only that case consumes without popping.
  assign pop    = accept && !((state_q == ALIGNED) && out_is_compressed_o);
  assign wr_idx = pop ? (count_q - CW'(1)) : count_q;

  // ---------------------------------------------------------------------------
  // FIFO storage.
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; count_q alone decides which entries are
  // meaningful and all payload outputs are gated by out_valid_o.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pop) fifo_q[i] <= fifo_q[i+1];
    end
    // Placed after the shift so a push into the slot vacated by a pop wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (CW'(i) == wr_idx)) fifo_q[i] <= '{err: in_err_i, rdata: in_rdata_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Control: occupancy, half pointer and PC.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      state_q <= ALIGNED;
      addr_q  <= 32'h0;
    end else if (branch_i) begin
      count_q <= '0;
      addr_q  <= {branch_addr_i[31:1], 1'b0};
      state_q <= branch_addr_i[1] ? UNALIGNED : ALIGNED;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (accept) begin
        addr_q <= addr_q + (out_is_compressed_o ? 32'd2 : 32'd4);
        // Compressed instructions flip the half pointer; 32-bit ones keep it.
        if (out_is_compressed_o) begin
          state_q <= (state_q == ALIGNED) ? UNALIGNED : ALIGNED;
        end
      end
    end
  end

endmodule

// File: tb/tb_vcve2_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_vcve2_fetch_aligner
//
// Self-checking bench for vcve2_fetch_aligner. The reference model views the
// fetched stream as a queue of halfwords (each tagged with its word id and
// error flag) plus a PC: an instruction is the front halfword (RVC) or the
// front two halfwords (32-bit). Directed scenarios come first, followed by a
// randomized phase with redirects, errors and backpressure.
// -----------------------------------------------------------------------------
module tb_vcve2_fetch_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic        out_err_o;

  vcve2_fetch_aligner #(.DEPTH(2)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .branch_i            (branch_i),
    .branch_addr_i       (branch_addr_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .in_rdata_i          (in_rdata_i),
    .in_err_i            (in_err_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_rdata_o         (out_rdata_o),
    .out_addr_o          (out_addr_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_err_o           (out_err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Reference model: halfword queue + PC.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] h;
    logic        err;
    int          wid;
  } half_t;

  half_t       q[$];
  logic [31:0] m_pc;
  bit          m_skip;   // drop the lower half of the next accepted word
  int          m_wid;

  bit          e_valid;
  bit          e_ready;
  logic [31:0] e_rdata;
  bit          e_err;
  bit          e_comp;
  int          e_used;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 32'h0;
    m_skip = 1'b0;
  endtask

  task automatic model_eval();
    int words;
    e_valid = 1'b0;
    e_rdata = '0;
    e_err   = 1'b0;
    e_comp  = 1'b0;
    e_used  = 0;
    words   = (q.size() == 0) ? 0 : (q[$].wid - q[0].wid + 1);
    e_ready = (words < 2);
    if (q.size() > 0) begin
      if (q[0].h[1:0] != 2'b11) begin
        e_valid = 1'b1; e_comp = 1'b1; e_used = 1;
        e_rdata = {16'h0, q[0].h};
        e_err   = q[0].err;
      end else if (q.size() >= 2) begin
        e_valid = 1'b1; e_used = 2;
        e_rdata = {q[1].h, q[0].h};
        e_err   = q[0].err | q[1].err;
      end else if (q[0].err) begin
        // Faulted first half of a 32-bit instruction: reported alone.
        e_valid = 1'b1; e_used = 1;
        e_rdata = {16'h0, q[0].h};
        e_err   = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    model_eval();
    check("valid", out_valid_o, e_valid);
    check("in_ready", in_ready_o, e_ready);
    check("addr", out_addr_o, m_pc);
    if (e_valid) begin
      check("rdata", out_rdata_o, e_rdata);
      check("err", out_err_o, e_err);
      check("compressed", out_is_compressed_o, e_comp);
    end
  endtask

  task automatic model_update(input bit br, input logic [31:0] ba, input bit iv,
                              input logic [31:0] d, input bit ie, input bit ordy);
    if (br) begin
      q.delete();
      m_pc   = {ba[31:1], 1'b0};
      m_skip = ba[1];
    end else begin
      if (e_valid && ordy) begin
        m_pc = m_pc + (e_comp ? 32'd2 : 32'd4);
        repeat (e_used) void'(q.pop_front());
        // A lone faulted 32-bit start consumed the upper half; the following
        // word's lower half belongs to that instruction and is skipped.
        if (!e_comp && e_used == 1) m_skip = 1'b1;
      end
      if (iv && e_ready) begin
        m_wid++;
        if (!m_skip) q.push_back('{h: d[15:0], err: ie, wid: m_wid});
        q.push_back('{h: d[31:16], err: ie, wid: m_wid});
        m_skip = 1'b0;
      end
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance model at the edge.
  task automatic step(input bit br, input logic [31:0] ba, input bit iv,
                      input logic [31:0] d, input bit ie, input bit ordy);
    check_model();
    branch_i      = br;
    branch_addr_i = ba;
    in_valid_i    = iv;
    in_rdata_i    = d;
    in_err_i      = ie;
    out_ready_i   = ordy;
    @(posedge clk_i);
    model_update(br, ba, iv, d, ie, ordy);
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[1:0]   = 2'b11;
    if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  initial begin
    rst_ni = 1'b0; branch_i = 1'b0; branch_addr_i = '0; in_valid_i = 1'b0;
    in_rdata_i = '0; in_err_i = 1'b0; out_ready_i = 1'b0;
    m_wid = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_ready", in_ready_o, 1'b1);
    check("rst_rdata", out_rdata_o, 32'h0);
    check("rst_addr", out_addr_o, 32'h0);
    check("rst_comp", out_is_compressed_o, 1'b0);
    check("rst_err", out_err_o, 1'b0);
    rst_ni = 1'b1;

    // Two 32-bit instructions from address 0.
    phase = "aligned32";
    step(0, 0, 1, 32'h00130013, 0, 0);
    step(0, 0, 1, 32'h00000013, 0, 0);
    check("first", out_rdata_o, 32'h00130013);
    check("first_addr", out_addr_o, 32'h0);
    check("first_comp", out_is_compressed_o, 1'b0);
    step(0, 0, 0, 0, 0, 1);
    check("second", out_rdata_o, 32'h00000013);
    check("second_addr", out_addr_o, 32'h4);
    step(0, 0, 0, 0, 0, 1);

    // Two c.li in one word.
    phase = "rvc_pair";
    step(1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 1, 32'h45014501, 0, 0);
    check("lo", out_rdata_o, 32'h00004501);
    check("lo_addr", out_addr_o, 32'h100);
    check("lo_comp", out_is_compressed_o, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    check("hi_valid", out_valid_o, 1'b1);
    check("hi", out_rdata_o, 32'h00004501);
    check("hi_addr", out_addr_o, 32'h102);
    step(0, 0, 0, 0, 0, 1);
    check("drained", out_valid_o, 1'b0);

    // 32-bit instruction straddling two words.
    phase = "straddle";
    step(1, 32'h202, 0, 0, 0, 0);
    step(0, 0, 1, 32'h00930001, 0, 0);
    check("wait_word1", out_valid_o, 1'b0);
    step(0, 0, 1, 32'h00000000, 0, 0);
    check("valid", out_valid_o, 1'b1);
    check("rdata", out_rdata_o, 32'h00000093);
    check("addr", out_addr_o, 32'h202);
    step(0, 0, 0, 0, 0, 1);
    check("next_addr", out_addr_o, 32'h206);

    // Full FIFO held for 5 cycles.
    phase = "stall";
    step(1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h00130013, 0, 0);
    step(0, 0, 1, 32'h45014501, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'hDEADBEEF, 0, 0);
      check("full_ready", in_ready_o, 1'b0);
      check("held_rdata", out_rdata_o, 32'h00130013);
      check("held_addr", out_addr_o, 32'h0);
    end
    step(0, 0, 0, 0, 0, 1);
    check("d1", out_rdata_o, 32'h00004501);
    check("d1_addr", out_addr_o, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    check("d2", out_rdata_o, 32'h00004501);
    check("d2_addr", out_addr_o, 32'h6);
    step(0, 0, 0, 0, 0, 1);
    check("d3_valid", out_valid_o, 1'b0);
    check("d3_addr", out_addr_o, 32'h8);

    // Bus errors.
    phase = "err_second";
    step(1, 32'h302, 0, 0, 0, 0);
    step(0, 0, 1, 32'h00930001, 0, 0);
    step(0, 0, 1, 32'h00000000, 1, 0);
    check("valid", out_valid_o, 1'b1);
    check("err", out_err_o, 1'b1);
    check("rdata", out_rdata_o, 32'h00000093);
    step(0, 0, 0, 0, 0, 1);
    phase = "err_single";
    step(1, 32'h402, 0, 0, 0, 0);
    step(0, 0, 1, 32'h00930001, 1, 0);
    check("valid", out_valid_o, 1'b1);
    check("err", out_err_o, 1'b1);
    check("rdata", out_rdata_o, 32'h00000093);
    check("addr", out_addr_o, 32'h402);
    step(0, 0, 0, 0, 0, 1);
    check("addr_after", out_addr_o, 32'h406);

    // Redirect together with a push and an accept.
    phase = "branch_combo";
    step(1, 32'h500, 0, 0, 0, 0);
    step(0, 0, 1, 32'h45014501, 0, 0);
    check("pre_valid", out_valid_o, 1'b1);
    step(1, 32'h00001237, 1, 32'hCAFEF00D, 0, 1);
    check("valid", out_valid_o, 1'b0);
    check("addr", out_addr_o, 32'h00001236);
    check("ready", in_ready_o, 1'b1);

    // Asynchronous reset mid-stream.
    phase = "async_reset";
    step(0, 0, 1, rand_word(), 0, 0);
    step(0, 0, 1, rand_word(), 0, 0);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("valid", out_valid_o, 1'b0);
    check("ready", in_ready_o, 1'b1);
    check("rdata", out_rdata_o, 32'h0);
    check("addr", out_addr_o, 32'h0);
    check("comp", out_is_compressed_o, 1'b0);
    check("err", out_err_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Randomized traffic against the halfword model.
    phase = "random";
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
           rand_word(), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
